mac_job_sequencer: RTL
======================

// Module: mac_job_sequencer
// PURPOSE
// Byte-serial job controller for the shared 7x8 iterative-MAC multiplier.
// - Accepts one job on an 8-bit valid/ready stream: header, 4-byte bias, N (activation, weight) pairs.
// - Drives the external multiplier, accumulates bias + sum(a_i*w_i) into a 32-bit register.
// - Returns the result as 4 bytes, MSB first, on an 8-bit valid/ready stream.
// - Sits between the chip byte pins and the multiplier core. It replaces per-byte host sequencing.
// PARAMETERS
// LEN_W   4   width of header length field; N = len+1, range 1..2**LEN_W
// ACC_W   32  accumulator/result width (fixed 32; the 4-byte bias and result framing depend on it)
// PORTS
// clk        in   1   clock, all state on rising edge
// rst_n      in   1   asynchronous active-low reset
// abort      in   1   synchronous soft clear, returns to IDLE
// in_valid   in   1   input byte valid
// in_ready   out  1   input byte accepted when in_valid & in_ready
// in_data    in   8   header / bias / activation / weight byte
// out_valid  out  1   result byte valid
// out_ready  in   1   result byte consumed when out_valid & out_ready
// out_data   out  8   result byte
// mul_a      out  7   multiplier operand A (activation)
// mul_b      out  8   multiplier operand B (weight)
// mul_p      in   15  combinational product mul_a*mul_b from shared multiplier
// busy       out  1   state != IDLE
// ovf        out  1   sticky per job: accumulation carried out of bit 31
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, acc=0, cnt=0, act=0, sat=0, ovf=0.
//   - Outputs: in_ready=1, out_valid=0, out_data=0x00, mul_a=0, mul_b=0, busy=0.
// - A byte transfer happens only on a clk edge with in_valid&in_ready. Idle cycles between bytes are legal.
// - States:
//   - IDLE: accept header.
//     - sat <= hdr[7]; cnt <= hdr[LEN_W-1:0]; hdr[6:LEN_W] ignored.
//     - acc <= 0, ovf <= 0. -> BIAS.
//   - BIAS: 4 bytes, LSB first, into acc[8k+7:8k] for k=0..3 (2-bit byte counter). -> ACT after the 4th byte.
//   - ACT: accept activation. act <= in_data[6:0]; bit 7 ignored. -> WGT.
//   - WGT: mul_b = in_data (combinational), mul_a = act.
//     - On accept: acc <= acc + mul_p (33-bit add).
//     - Then cnt==0 -> OUT, else cnt <= cnt-1 and -> ACT.
//   - OUT: in_ready=0, out_valid=1.
//     - out_data = acc byte 3,2,1,0 in turn; the byte index advances only on out_valid&out_ready.
//     - -> IDLE after byte 0 is taken.
// - in_ready=1 in IDLE/BIAS/ACT/WGT, 0 in OUT. mul_b=0 outside WGT. mul_a holds act.
// - Latency: out_valid rises the cycle after the last weight is accepted. Minimum job = 1+4+2N+4 cycles.
// - Arithmetic: unsigned.
//   - Carry out of bit 31 sets ovf.
//   - sat=0: acc keeps the low 32 bits (wrap).
//   - sat=1: acc <= 0xFFFFFFFF and further adds leave it saturated.
//   - ovf stays set until the next header.
// - Backpressure: while out_ready=0, out_data and out_valid are held stable.
// - abort=1 takes priority over any handshake in the same cycle.
//   - Next edge: state=IDLE, acc=0, ovf=0. The byte offered that cycle is dropped.
// - rst_n low mid-job: outputs take reset values immediately, no clock needed. The job is lost.
// - No per-byte type check. The host must send exactly 5+2N bytes per job.
// TESTING
// - T1 basic: in 00 | 10 00 00 00 | 03 05 -> out 00 00 00 1F, ovf=0, busy low after last out byte.
// - T2 full length: hdr 0F, bias 0, 16x(7F,FF) -> out 00 07 E8 10, ovf=0.
//   - Activation byte FF gives the same result as 7F (bit 7 ignored).
// - T3 overflow:
//   - hdr 00, bias FF FF FF FF, (01,02) -> out 00 00 00 01, ovf=1.
//   - Same job with hdr 80 -> out FF FF FF FF, ovf=1.
// - T4 backpressure:
//   - out_ready=0 for 5 cycles at byte 2 -> out_data stable, in_ready=0, all 4 bytes delivered once in order.
//   - Random in_valid gaps on T1 -> identical output.
// - T5 abort: assert abort in WGT of T2 after 7 pairs -> next cycle busy=0, out_valid=0.
//   - A following T1 job yields 00 00 00 1F.
// - T6 async reset: drop rst_n mid-BIAS between clk edges -> busy=0, in_ready=1, ovf=0 before next edge.
//   - T1 then passes.

Source files
------------

// File: rtl/mac_job_sequencer.sv
// Byte-serial job controller for the shared 7x8 multiplier: takes header, bias and
// (activation, weight) pairs, accumulates bias + sum(a*w), returns 4 result bytes MSB first.
module mac_job_sequencer #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [6:0] mul_a,
    output logic [7:0] mul_b,
    input  logic [14:0] mul_p,
    output logic       busy,
    output logic       ovf
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_BIAS = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_WGT  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]       state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic [6:0]       act;
    logic             sat;
    logic [1:0]       bidx;
    logic             accept;
    logic [ACC_W:0]   sum;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W:0] s, input logic sat_en);
        if (s[ACC_W] && sat_en)
            return '1;
        return s[ACC_W-1:0];
    endfunction

    assign accept    = in_valid & in_ready;
    assign sum       = {1'b0, acc} + {{(ACC_W + 1 - 15){1'b0}}, mul_p};
    assign in_ready  = (state != S_OUT);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign mul_a     = act;
    assign mul_b     = (state == S_WGT) ? in_data : 8'h00;
    // bidx counts 0..3 while the result byte sent is 3..0, hence the inverted index
    assign out_data  = (state == S_OUT) ? 8'(acc >> {~bidx, 3'b000}) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            act   <= '0;
            sat   <= 1'b0;
            ovf   <= 1'b0;
            bidx  <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            ovf   <= 1'b0;
            bidx  <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    sat   <= in_data[7];
                    cnt   <= in_data[LEN_W-1:0];
                    acc   <= '0;
                    ovf   <= 1'b0;
                    bidx  <= '0;
                    state <= S_BIAS;
                end
                S_BIAS: if (accept) begin
                    acc[8*bidx +: 8] <= in_data;
                    bidx             <= bidx + 2'd1;
                    if (bidx == 2'd3)
                        state <= S_ACT;
                end
                S_ACT: if (accept) begin
                    act   <= in_data[6:0];
                    state <= S_WGT;
                end
                S_WGT: if (accept) begin
                    acc <= sat_add(sum, sat);
                    if (sum[ACC_W])
                        ovf <= 1'b1;
                    if (cnt == '0) begin
                        state <= S_OUT;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= S_ACT;
                    end
                end
                S_OUT: if (out_ready) begin
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
